// File: rtl/safety_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | safety_pkg : shared FSM encoding, thresholds and offset-binary helper      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package safety_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        EVAL   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam logic [15:0] MID     = 16'h7fff;
    localparam logic [15:0] DB_LO   = 16'h7d00;
    localparam logic [15:0] DB_HI   = 16'h8300;
    localparam logic [15:0] SIGN_HI = 16'h7ff0;
    localparam logic [15:0] SIGN_LO = 16'h800f;

    // Distance from mid-scale; full-scale high (16'hffff) yields 16'h8000.
    function automatic logic [15:0] abs_offset(input logic [15:0] x);
        return (x > MID) ? (x - MID) : (MID - x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/safety_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | safety_eval : shared magnitude register and pass/violation classifier     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module safety_eval
    import safety_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_eval_en,
    input  logic [15:0] i_cur,
    input  logic [15:0] i_dac,
    output logic        o_pass,
    output logic        o_violation
);

    logic [15:0] r_abs_cur;
    logic [15:0] r_abs_dac;
    logic        w_same_sign;
    logic        w_over;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_abs_cur <= '0;
            r_abs_dac <= '0;
        end else if (i_eval_en) begin
            r_abs_cur <= abs_offset(i_cur);
            r_abs_dac <= abs_offset(i_dac);
        end
    end

    // Doubled command kept at 17 bits so abs_dac = 16'h8000 cannot wrap.
    always_comb begin
        o_pass      = (i_cur > DB_LO) && (i_cur < DB_HI);
        w_same_sign = ((i_cur > SIGN_HI) && (i_dac > SIGN_HI)) ||
                      ((i_cur < SIGN_LO) && (i_dac < SIGN_LO));
        w_over      = {1'b0, r_abs_cur} > {r_abs_dac, 1'b0};
        o_violation = w_same_sign && w_over && !o_pass;
    end

endmodule
`default_nettype wire

// File: rtl/safety_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | safety_scheduler : round-robin current/command supervisor with sticky     |
// | per-channel amplifier disable and host clear handshake.  Rev 1.0          |
// +----------------------------------------------------------------------------+
module safety_scheduler
    import safety_pkg::*;
#(
    parameter int    NUM_CH      = 4,
    parameter int    FAULT_COUNT = 4,
    localparam int   CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [16*NUM_CH-1:0] cur_in,
    input  logic [16*NUM_CH-1:0] dac_in,
    input  logic                 scan_en,
    input  logic                 clr_req,
    input  logic [NUM_CH-1:0]    clr_mask,
    output logic                 clr_ack,
    output logic [NUM_CH-1:0]    amp_disable,
    output logic                 fault_any,
    output logic                 scan_done,
    output logic [CH_W-1:0]      scan_ch
);

    localparam int              CNT_W   = $clog2(FAULT_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAULT_COUNT);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_sample_en;
    logic              w_eval_en;
    logic              w_update_en;
    logic              w_clr_win;
    logic              w_clr_take;

    logic [CH_W-1:0]   r_scan_ch;
    logic              r_scan_done;
    logic              r_clr_ack;
    logic              r_fault_any;
    logic [NUM_CH-1:0] r_amp_disable;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [15:0]       r_cur;
    logic [15:0]       r_dac;

    logic [15:0]       w_cur_sel;
    logic [15:0]       w_dac_sel;
    logic [CNT_W-1:0]  w_cnt_sel;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_pass;
    logic              w_violation;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = scan_en ? SAMPLE : IDLE;
            SAMPLE:  w_next_state = EVAL;
            EVAL:    w_next_state = UPDATE;
            UPDATE:  w_next_state = scan_en ? SAMPLE : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_sample_en = (r_state == SAMPLE);
        w_eval_en   = (r_state == EVAL);
        w_update_en = (r_state == UPDATE);
        w_clr_win   = (r_state == IDLE) || (r_state == SAMPLE);
    end

    // The ack register doubles as the one-cycle lockout between requests.
    assign w_clr_take = w_clr_win && clr_req && !r_clr_ack;

    always_comb begin
        w_cur_sel = '0;
        w_dac_sel = '0;
        w_cnt_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == r_scan_ch) begin
                w_cur_sel = cur_in[16*k +: 16];
                w_dac_sel = dac_in[16*k +: 16];
                w_cnt_sel = r_cnt[k];
            end
        end
    end

    always_comb begin
        w_cnt_next = '0;
        if (w_violation)
            w_cnt_next = (w_cnt_sel == CNT_MAX) ? CNT_MAX : w_cnt_sel + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur <= '0;
            r_dac <= '0;
        end else if (w_sample_en) begin
            r_cur <= w_cur_sel;
            r_dac <= w_dac_sel;
        end
    end

    safety_eval u_eval (
        .clk         (clk),
        .reset       (reset),
        .i_eval_en   (w_eval_en),
        .i_cur       (r_cur),
        .i_dac       (r_dac),
        .o_pass      (w_pass),
        .o_violation (w_violation)
    );

    // Clear and update never coincide: clear is only taken in IDLE/SAMPLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
            r_amp_disable <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_clr_take && clr_mask[i]) begin
                    r_cnt[i]         <= '0;
                    r_amp_disable[i] <= 1'b0;
                end else if (w_update_en && (CH_W'(i) == r_scan_ch)) begin
                    r_cnt[i] <= w_cnt_next;
                    if (w_cnt_next == CNT_MAX) r_amp_disable[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_ch   <= '0;
            r_scan_done <= 1'b0;
            r_clr_ack   <= 1'b0;
            r_fault_any <= 1'b0;
        end else begin
            r_scan_done <= w_update_en && (r_scan_ch == LAST_CH);
            r_clr_ack   <= w_clr_take;
            r_fault_any <= |r_amp_disable;
            if (w_update_en)
                r_scan_ch <= ((r_scan_ch == LAST_CH) || !scan_en) ? '0 : r_scan_ch + 1'b1;
        end
    end

    assign clr_ack     = r_clr_ack;
    assign amp_disable = r_amp_disable;
    assign fault_any   = r_fault_any;
    assign scan_done   = r_scan_done;
    assign scan_ch     = r_scan_ch;

endmodule
`default_nettype wire

// File: tb/tb_safety_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_safety_scheduler : randomized stimulus against a slot-level model       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_safety_scheduler;

    localparam int NUM_CH      = 4;
    localparam int FAULT_COUNT = 4;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b0;
    logic [16*NUM_CH-1:0] cur_in;
    logic [16*NUM_CH-1:0] dac_in;
    logic                 scan_en  = 1'b0;
    logic                 clr_req  = 1'b0;
    logic [NUM_CH-1:0]    clr_mask = '0;
    logic                 clr_ack;
    logic [NUM_CH-1:0]    amp_disable;
    logic                 fault_any;
    logic                 scan_done;
    logic [1:0]           scan_ch;

    logic [15:0] cur_v [NUM_CH];
    logic [15:0] dac_v [NUM_CH];

    int n_checks = 0;
    int n_errors = 0;
    int clr_wait = 0;

    // Model: m_pos = -1 idle, 0 sample pending, 1 magnitude pending, 2 decision pending.
    int          m_pos;
    int          m_ch;
    int          m_cnt [NUM_CH];
    bit          m_dis [NUM_CH];
    bit          m_fault, m_ack, m_done;
    logic [15:0] m_cur, m_dac;

    safety_scheduler #(.NUM_CH(NUM_CH), .FAULT_COUNT(FAULT_COUNT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cur_in      (cur_in),
        .dac_in      (dac_in),
        .scan_en     (scan_en),
        .clr_req     (clr_req),
        .clr_mask    (clr_mask),
        .clr_ack     (clr_ack),
        .amp_disable (amp_disable),
        .fault_any   (fault_any),
        .scan_done   (scan_done),
        .scan_ch     (scan_ch)
    );

    always #5 clk = ~clk;

    always_comb begin
        cur_in = '0;
        dac_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cur_in[16*k +: 16] = cur_v[k];
            dac_in[16*k +: 16] = dac_v[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_violation(input logic [15:0] c, input logic [15:0] d);
        int ci, di, ac, ad;
        bit pass, same;
        ci   = int'(c) - 32767;
        di   = int'(d) - 32767;
        ac   = (ci < 0) ? -ci : ci;
        ad   = (di < 0) ? -di : di;
        pass = (c > 16'h7d00) && (c < 16'h8300);
        same = ((c > 16'h7ff0) && (d > 16'h7ff0)) || ((c < 16'h800f) && (d < 16'h800f));
        return same && (ac > 2 * ad) && !pass;
    endfunction

    function automatic logic [NUM_CH-1:0] dis_vec();
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k] = m_dis[k];
        return v;
    endfunction

    task automatic model_reset();
        m_pos = -1; m_ch = 0; m_fault = 0; m_ack = 0; m_done = 0;
        m_cur = '0; m_dac = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_cnt[k] = 0;
            m_dis[k] = 0;
        end
    endtask

    task automatic model_step();
        bit any_dis;
        bit ack_old;
        any_dis = 1'b0;
        ack_old = m_ack;
        for (int k = 0; k < NUM_CH; k++) any_dis |= m_dis[k];
        m_fault = any_dis;
        m_ack   = 1'b0;
        m_done  = 1'b0;
        if ((m_pos == -1 || m_pos == 0) && clr_req && !ack_old) begin
            for (int k = 0; k < NUM_CH; k++)
                if (clr_mask[k]) begin
                    m_dis[k] = 1'b0;
                    m_cnt[k] = 0;
                end
            m_ack = 1'b1;
        end
        if (m_pos == -1) begin
            if (scan_en) m_pos = 0;
        end else if (m_pos == 0) begin
            m_cur = cur_v[m_ch];
            m_dac = dac_v[m_ch];
            m_pos = 1;
        end else if (m_pos == 1) begin
            m_pos = 2;
        end else begin
            if (is_violation(m_cur, m_dac)) begin
                if (m_cnt[m_ch] < FAULT_COUNT) m_cnt[m_ch]++;
                if (m_cnt[m_ch] == FAULT_COUNT) m_dis[m_ch] = 1'b1;
            end else begin
                m_cnt[m_ch] = 0;
            end
            if (m_ch == NUM_CH - 1) m_done = 1'b1;
            if (scan_en) begin
                m_pos = 0;
                m_ch  = (m_ch + 1) % NUM_CH;
            end else begin
                m_pos = -1;
                m_ch  = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("amp_disable", 32'(amp_disable), 32'(dis_vec()));
        check("fault_any",   32'(fault_any),   32'(m_fault));
        check("clr_ack",     32'(clr_ack),     32'(m_ack));
        check("scan_done",   32'(scan_done),   32'(m_done));
        check("scan_ch",     32'(scan_ch),     32'(m_ch));
    endtask

    task automatic host_tick();
        if (clr_req) begin
            if (clr_ack) begin
                clr_req = 1'b0;
            end else begin
                clr_wait++;
                if (clr_wait > 6) begin
                    check("clr_ack_latency", 32'(clr_wait), 32'd3);
                    clr_req = 1'b0;
                end
            end
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step();
        #1;
        compare_all();
        host_tick();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic request_clear(input logic [NUM_CH-1:0] m);
        clr_mask = m;
        clr_req  = 1'b1;
        clr_wait = 0;
    endtask

    task automatic finish_clear();
        while (clr_req) step_cycle();
    endtask

    task automatic set_pattern(input int ch, input int p);
        case (p)
            0: begin cur_v[ch] = 16'(32'h7d01 + $urandom_range(0, 32'h5fe)); dac_v[ch] = 16'($urandom); end
            1: begin cur_v[ch] = 16'(32'hc000 + $urandom_range(0, 32'hfff)); dac_v[ch] = 16'h8800; end
            2: begin cur_v[ch] = 16'h2000; dac_v[ch] = 16'h7800; end
            3: begin cur_v[ch] = 16'hf000; dac_v[ch] = 16'h2000; end
            4: begin cur_v[ch] = 16'h0000; dac_v[ch] = 16'hffff; end
            5: begin cur_v[ch] = 16'($urandom); dac_v[ch] = 16'($urandom); end
            6: begin cur_v[ch] = 16'h8300; dac_v[ch] = 16'h8000; end
            7: begin cur_v[ch] = 16'h8fff; dac_v[ch] = 16'h87ff; end
            default: begin cur_v[ch] = 16'h9000; dac_v[ch] = 16'h87ff; end
        endcase
    endtask

    task automatic all_deadband();
        for (int k = 0; k < NUM_CH; k++) begin
            cur_v[k] = 16'h8000;
            dac_v[k] = 16'h9000;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        all_deadband();
        model_reset();
        #11;
        check("rst_amp_disable", 32'(amp_disable), 32'd0);
        check("rst_fault_any",   32'(fault_any),   32'd0);
        check("rst_clr_ack",     32'(clr_ack),     32'd0);
        check("rst_scan_done",   32'(scan_done),   32'd0);
        check("rst_scan_ch",     32'(scan_ch),     32'd0);
        reset = 1'b1;

        // Deadband: ten full scans with no fault.
        scan_en = 1'b1;
        run(121);
        check("deadband_amp", 32'(amp_disable), 32'd0);

        // Latch on channel 2 only.
        cur_v[2] = 16'hc000; dac_v[2] = 16'h8800;
        run(60);
        check("latch_ch2_amp",   32'(amp_disable), 32'b0100);
        check("latch_ch2_fault", 32'(fault_any),   32'd1);

        // Sticky and selective clear of channel 0.
        cur_v[0] = 16'hc000; dac_v[0] = 16'h8800;
        cur_v[3] = 16'h2000; dac_v[3] = 16'h7800;
        cur_v[2] = 16'h8000; dac_v[2] = 16'h9000;
        run(60);
        check("sticky_amp", 32'(amp_disable), 32'b1101);
        request_clear(4'b0001);
        finish_clear();
        check("clear_ch0_amp", 32'(amp_disable), 32'b1100);
        run(60);
        check("relatch_ch0_amp", 32'(amp_disable), 32'b1101);

        // Persistence restarts after one non-violating sample.
        all_deadband();
        request_clear(4'b1111);
        finish_clear();
        cur_v[1] = 16'hc000; dac_v[1] = 16'h8800;
        run(36);
        dac_v[1] = 16'ha000;
        run(12);
        dac_v[1] = 16'h8800;
        run(36);
        check("persist_no_latch", 32'(amp_disable[1]), 32'd0);
        run(24);
        check("persist_latch", 32'(amp_disable[1]), 32'd1);

        // Opposite sign and full-scale overflow never latch.
        all_deadband();
        cur_v[0] = 16'hf000; dac_v[0] = 16'h2000;
        cur_v[3] = 16'h0000; dac_v[3] = 16'hffff;
        request_clear(4'b1111);
        finish_clear();
        run(120);
        check("no_latch_amp", 32'(amp_disable), 32'd0);

        // Randomized traffic: patterns, scan gating and clears.
        for (int cyc = 0; cyc < 2400; cyc++) begin
            if ($urandom_range(0, 19) == 0)
                set_pattern(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 8)));
            if (!scan_en && $urandom_range(0, 5) == 0) scan_en = 1'b1;
            else if (scan_en && $urandom_range(0, 59) == 0) scan_en = 1'b0;
            if (!clr_req && $urandom_range(0, 79) == 0)
                request_clear(NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)));
            step_cycle();
        end
        finish_clear();

        // Reset during EVAL of channel 1 while its counter sits at 3.
        scan_en = 1'b1;
        all_deadband();
        request_clear(4'b1111);
        finish_clear();
        cur_v[1] = 16'hc000; dac_v[1] = 16'h8800;
        guard = 0;
        while (!(m_cnt[1] == 3 && m_ch == 1 && m_pos == 1) && guard < 200) begin
            step_cycle();
            guard++;
        end
        check("reach_ch1_eval", 32'(guard < 200), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_amp",   32'(amp_disable), 32'd0);
        check("midrst_fault", 32'(fault_any),   32'd0);
        check("midrst_ack",   32'(clr_ack),     32'd0);
        check("midrst_done",  32'(scan_done),   32'd0);
        check("midrst_ch",    32'(scan_ch),     32'd0);
        model_reset();
        step_cycle();
        reset = 1'b1;
        run(40);
        check("post_rst_no_latch", 32'(amp_disable[1]), 32'd0);
        run(20);
        check("post_rst_latch", 32'(amp_disable[1]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
